// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one iterative multiplier between N requesters,
// with per-job timeout abort and a shared result bus.
module mul_share_arb #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int IDW = 2,
  parameter int TMO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     ack,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [2*W-1:0]   res_product,
  output logic             res_err,
  output logic             busy,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_product,
  input  logic             mul_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, gid_q, gid_d, sel, idx;
  logic [9:0]     cnt_q, cnt_d;
  logic           err_q, err_d, found;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W-1:0] prod_q, prod_d;
  // Descending scan so the last hit written is the closest to ptr in round-robin order.
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % N);
      if (req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    cnt_d = cnt_q;
    err_d = err_q;
    a_d = a_q;
    b_d = b_q;
    prod_d = prod_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = RUN;
        gid_d = sel;
        a_d = req_a[int'(sel)*W +: W];
        b_d = req_b[int'(sel)*W +: W];
        cnt_d = '0;
        prod_d = '0;
      end
      RUN: begin
        cnt_d = cnt_q + 10'd1;
        if (mul_done) begin
          prod_d = mul_product;
          state_d = DRAIN;
        end else if (cnt_q == 10'(TMO - 1)) begin
          err_d = 1'b1;
          prod_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = mul_done ? DRAIN : DONE;
      DONE: begin
        ptr_d = (int'(gid_q) == N - 1) ? '0 : gid_q + 1'b1;
        cnt_d = '0;
        err_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gid_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      a_q <= a_d;
      b_q <= b_d;
      prod_q <= prod_d;
    end
  end
  assign busy = state_q != IDLE;
  assign mul_start = state_q == RUN;
  assign res_valid = state_q == DONE;
  assign ack = res_valid ? N'(1) << gid_q : '0;
  assign res_id = res_valid ? gid_q : '0;
  assign res_err = res_valid & err_q;
  assign res_product = prod_q;
  assign mul_a = a_q;
  assign mul_b = b_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed checks of arbitration order, latency, timeout, drain and reset
// against a behavioural iterative multiplier with adjustable latency and drain hold.
module tb_mul_share_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0]  ack;
  logic        res_valid, res_err, busy, mul_start, mul_done;
  logic [1:0]  res_id;
  logic [31:0] res_product, mul_product;
  logic [15:0] mul_a, mul_b;
  int checks = 0, errors = 0;
  int m_lat = 20, hold = 0;
  bit stuck = 1'b0;
  int mcnt, dleft;

  always #5 clk = ~clk;

  mul_share_arb dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
    .res_err(res_err), .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  // done rises M cycles after start, optionally lingers hold cycles after start falls
  assign mul_product = 32'(mul_a) * 32'(mul_b);
  assign mul_done = (mul_start && !stuck && mcnt >= m_lat - 1) || dleft > 0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      mcnt <= 0;
      dleft <= 0;
    end else begin
      mcnt <= mul_start ? mcnt + 1 : 0;
      dleft <= (mul_start && mul_done) ? hold : (dleft > 0 ? dleft - 1 : 0);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (res_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ack, res_valid, res_id, res_product, res_err, busy, mul_start, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%h v=%b id=%h p=%h busy=%b start=%b required all 0",
               ack, res_valid, res_id, res_product, busy, mul_start);
    end
    checks++;
    if (dut.ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d required 0", dut.ptr_q);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b start=%b required 0 0", busy, mul_start);
    end
  endtask

  task automatic test_single();
    int got, bad;
    @(posedge clk);
    #1;
    req_a[32 +: 16] = 16'h1234;
    req_b[32 +: 16] = 16'h5678;
    req[2] = 1'b1;
    got = -1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy !== (c >= 1)) bad++;
      if (c == 5) req_a[32 +: 16] = 16'hdead;
      if (res_valid) begin
        got = c;
        break;
      end
    end
    checks++;
    if (got != 22) begin errors++; $display("FAIL single_latency: got %0d required 22", got); end
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b required 0100", ack); end
    checks++;
    if (res_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d required 2", res_id); end
    checks++;
    if (res_product !== 32'h06260060) begin
      errors++; $display("FAIL single_product: got %h required 06260060", res_product);
    end
    checks++;
    if (res_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b required 0", res_err); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_busy: got %0d wrong cycles required 0", bad); end
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL single_after: got busy=%b v=%b required 0 0", busy, res_valid);
    end
  endtask

  task automatic test_round_robin();
    int got;
    int exp_id[6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] prod[4] = '{32'd15, 32'h4E20, 32'hFFFE0001, 32'h10000};
    do_reset();
    req_a = {16'h8000, 16'hFFFF, 16'd100, 16'd3};
    req_b = {16'd2, 16'hFFFF, 16'd200, 16'd5};
    req = 4'hf;
    for (int j = 0; j < 6; j++) begin
      wait_valid(60, got);
      checks++;
      if (got < 0 || res_id !== 2'(exp_id[j])) begin
        errors++; $display("FAIL rr_id%0d: got %0d (cyc %0d) required %0d", j, res_id, got, exp_id[j]);
      end
      checks++;
      if (res_product !== prod[exp_id[j]]) begin
        errors++; $display("FAIL rr_product%0d: got %h required %h", j, res_product, prod[exp_id[j]]);
      end
      checks++;
      if (ack !== (4'b0001 << exp_id[j])) begin
        errors++; $display("FAIL rr_ack%0d: got %b required %b", j, ack, 4'b0001 << exp_id[j]);
      end
      @(posedge clk);
      #1;
      if (j == 5) req = '0;
      else begin
        req[exp_id[j]] = 1'b0;
        @(posedge clk);
        #1 req[exp_id[j]] = 1'b1;
      end
    end
  endtask

  task automatic test_fairness();
    int got;
    do_reset();
    req_a = {16'd7, 16'd0, 16'd4, 16'h10};
    req_b = {16'd9, 16'd0, 16'd4, 16'h10};
    req[1] = 1'b1;
    wait_valid(60, got);
    checks++;
    if (got != 22 || res_id !== 2'd1) begin
      errors++; $display("FAIL fair_setup: got id %0d cyc %0d required id 1 cyc 22", res_id, got);
    end
    @(posedge clk);
    #1 req = 4'b1001;
    wait_valid(60, got);
    checks++;
    if (got != 22 || res_id !== 2'd3 || res_product !== 32'd63) begin
      errors++; $display("FAIL fair_first: got id %0d p %0d cyc %0d required id 3 p 63 cyc 22", res_id, res_product, got);
    end
    @(posedge clk);
    #1 req[3] = 1'b0;
    wait_valid(60, got);
    checks++;
    if (res_id !== 2'd0 || res_product !== 32'h100) begin
      errors++; $display("FAIL fair_second: got id %0d p %h required id 0 p 100", res_id, res_product);
    end
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL fair_ptr: got %0d required 1", dut.ptr_q); end
  endtask

  task automatic test_timeout();
    int fall, got, seen;
    @(posedge clk);
    #1;
    stuck = 1'b1;
    req_a[0 +: 16] = 16'd2;
    req_b[0 +: 16] = 16'd3;
    req[0] = 1'b1;
    fall = -1;
    got = -1;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mul_start) seen = 1;
      else if (seen != 0 && fall < 0) fall = c;
      if (res_valid) begin
        got = c;
        break;
      end
    end
    checks++;
    if (fall != 65) begin errors++; $display("FAIL tmo_start_drop: got cycle %0d required 65", fall); end
    checks++;
    if (got != 66) begin errors++; $display("FAIL tmo_ack_cycle: got %0d required 66", got); end
    checks++;
    if (res_err !== 1'b1 || ack !== 4'b0001) begin
      errors++; $display("FAIL tmo_err: got err=%b ack=%b required 1 0001", res_err, ack);
    end
    checks++;
    if (res_product !== 32'd0) begin errors++; $display("FAIL tmo_product: got %h required 0", res_product); end
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    stuck = 1'b0;
    @(posedge clk);
    #1;
    req_a[16 +: 16] = 16'd5;
    req_b[16 +: 16] = 16'd6;
    req[1] = 1'b1;
    wait_valid(60, got);
    checks++;
    if (got != 22 || res_err !== 1'b0 || res_product !== 32'd30) begin
      errors++; $display("FAIL tmo_recover: got cyc %0d err %b p %0d required 22 0 30", got, res_err, res_product);
    end
    @(posedge clk);
    #1 req[1] = 1'b0;
  endtask

  task automatic test_slow_drain();
    int got, bad;
    @(posedge clk);
    #1;
    hold = 5;
    req_a[32 +: 16] = 16'h100;
    req_b[32 +: 16] = 16'h100;
    req[2] = 1'b1;
    got = -1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c >= 21 && mul_start) bad++;
      if (res_valid) begin
        got = c;
        break;
      end
    end
    checks++;
    if (got != 27) begin errors++; $display("FAIL drain_latency: got %0d required 27", got); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drain_start_low: got %0d high cycles required 0", bad); end
    checks++;
    if (res_product !== 32'h10000 || ack !== 4'b0100) begin
      errors++; $display("FAIL drain_result: got p %h ack %b required 10000 0100", res_product, ack);
    end
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    hold = 0;
  endtask

  task automatic test_reset_mid_run();
    int got, bad;
    @(posedge clk);
    #1;
    req_a[48 +: 16] = 16'h55;
    req_b[48 +: 16] = 16'h66;
    req[3] = 1'b1;
    repeat (11) @(negedge clk);
    checks++;
    if (mul_start !== 1'b1) begin errors++; $display("FAIL rst_pre_run: got start %b required 1", mul_start); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, res_valid, res_id, res_product, res_err, busy, mul_start, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ack=%h busy=%b start=%b a=%h b=%h p=%h required all 0",
               ack, busy, mul_start, mul_a, mul_b, res_product);
    end
    req = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 4'b0 || res_valid !== 1'b0) bad++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack !== 4'b0 || res_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_ack: got %0d ack cycles required 0", bad); end
    @(posedge clk);
    #1;
    req_a[16 +: 16] = 16'd9;
    req_b[16 +: 16] = 16'd11;
    req = 4'b1010;
    wait_valid(60, got);
    checks++;
    if (got != 22 || res_id !== 2'd1 || res_product !== 32'd99) begin
      errors++; $display("FAIL rst_first_grant: got id %0d p %0d cyc %0d required id 1 p 99 cyc 22", res_id, res_product, got);
    end
    @(posedge clk);
    #1 req = '0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_slow_drain();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
